// File: rtl/if_id_queue.sv
// IF/ID decoupling FIFO of {pc, inst} pairs; emits a zero bubble when empty.
// Optional IFQ_BYPASS_EN: empty-queue instructions pass straight through to ID.
module if_id_queue #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              if_valid,
    input  logic [ADDR_W-1:0] if_pc,
    input  logic [INST_W-1:0] if_inst,
    output logic              if_ready,
    input  logic              id_ready,
    output logic              id_valid,
    output logic [ADDR_W-1:0] id_pc,
    output logic [INST_W-1:0] id_inst,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
    logic [INST_W-1:0] inst_mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic q_valid;
    logic push;
    logic pop;

    assign q_valid  = (count_q != '0);
    assign if_ready = (count_q != CNT_W'(DEPTH));
    assign count    = count_q;

    always_comb begin
        push     = if_valid && if_ready && !flush;
        pop      = q_valid && id_ready && !flush;
        id_valid = q_valid;
        id_pc    = q_valid ? pc_mem_q[rd_ptr_q] : '0;
        id_inst  = q_valid ? inst_mem_q[rd_ptr_q] : '0;
`ifdef IFQ_BYPASS_EN
        // Empty queue: hand the fetch straight to ID; skip storage if taken.
        if (!q_valid && if_valid && !flush) begin
            id_valid = 1'b1;
            id_pc    = if_pc;
            id_inst  = if_inst;
            if (id_ready) begin
                push = 1'b0;
            end
        end
`endif
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage carries no reset; validity comes from count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]   <= if_pc;
            inst_mem_q[wr_ptr_q] <= if_inst;
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed self-checking bench for if_id_queue (DEPTH=4).
// Covers reset, fill/drain, streaming across wrap, flush, full pop+push, bypass.
module tb_if_id_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_ready;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic [2:0]  count;

    int n_cmp = 0;
    int n_err = 0;

    if_id_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .if_valid (if_valid),
        .if_pc    (if_pc),
        .if_inst  (if_inst),
        .if_ready (if_ready),
        .id_ready (id_ready),
        .id_valid (id_valid),
        .id_pc    (id_pc),
        .id_inst  (id_inst),
        .count    (count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [31:0] base, input int n);
        id_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            if_valid = 1'b1;
            if_pc    = base + 32'(4 * i);
            if_inst  = 32'hA000_0000 | base | 32'(i);
            step();
        end
        if_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; if_valid = 1'b0;
        if_pc = '0; if_inst = '0; id_ready = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Idle after reset
        for (int c = 0; c < 3; c++) begin
            step();
            chk("idle_count", 64'(count), 64'd0);
            chk("idle_valid", 64'(id_valid), 64'd0);
            chk("idle_pc", 64'(id_pc), 64'd0);
            chk("idle_inst", 64'(id_inst), 64'd0);
            chk("idle_ready", 64'(if_ready), 64'd1);
        end

        // Fill to full with ID stalled
        id_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if_valid = 1'b1;
            if_pc    = 32'h100 + 32'(4 * i);
            if_inst  = 32'h1000 + 32'(i);
            step();
            chk("fill_count", 64'(count), 64'(i + 1));
        end
        chk("full_ready", 64'(if_ready), 64'd0);
        chk("full_head", 64'(id_pc), 64'h100);
        if_pc   = 32'h110;
        if_inst = 32'h1004;
        step();
        chk("fifth_rejected", 64'(count), 64'd4);
        if_valid = 1'b0;
        id_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_pc", 64'(id_pc), 64'(32'h100 + 32'(4 * i)));
            chk("drain_inst", 64'(id_inst), 64'(32'h1000 + 32'(i)));
            step();
        end
        chk("bubble_valid", 64'(id_valid), 64'd0);
        chk("bubble_pc", 64'(id_pc), 64'd0);
        chk("bubble_inst", 64'(id_inst), 64'd0);
        chk("bubble_count", 64'(count), 64'd0);

        // Streaming across the pointer wrap
        id_ready = 1'b1;
        if_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if_pc   = 32'h200 + 32'(4 * i);
            if_inst = 32'h2000 + 32'(i);
`ifdef IFQ_BYPASS_EN
            #1;
            chk("stream_byp_pc", 64'(id_pc), 64'(32'h200 + 32'(4 * i)));
            step();
            chk("stream_count", 64'(count), 64'd0);
`else
            step();
            chk("stream_count", 64'(count), 64'd1);
            chk("stream_pc", 64'(id_pc), 64'(32'h200 + 32'(4 * i)));
            chk("stream_inst", 64'(id_inst), 64'(32'h2000 + 32'(i)));
`endif
        end
        if_valid = 1'b0;
        step();
        chk("stream_end_count", 64'(count), 64'd0);

        // Flush with count=3 and a same-cycle push
        fill(32'h280, 3);
        chk("pre_flush_count", 64'(count), 64'd3);
        if_valid = 1'b1;
        if_pc    = 32'h300;
        if_inst  = 32'h3000;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
        if_valid = 1'b0;
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_valid", 64'(id_valid), 64'd0);
        chk("flush_pc", 64'(id_pc), 64'd0);
        chk("flush_ready", 64'(if_ready), 64'd1);
        step();
        chk("flush_no_300", 64'(id_valid), 64'd0);
        fill(32'h500, 1);
        chk("post_flush_count", 64'(count), 64'd1);
        chk("post_flush_pc", 64'(id_pc), 64'h500);
        id_ready = 1'b1;
        step();
        chk("post_flush_drain", 64'(count), 64'd0);

        // Full queue: pop happens, push rejected
        fill(32'h600, 4);
        chk("full2_count", 64'(count), 64'd4);
        chk("full2_ready", 64'(if_ready), 64'd0);
        if_valid = 1'b1;
        if_pc    = 32'h610;
        if_inst  = 32'h6100;
        id_ready = 1'b1;
        step();
        if_valid = 1'b0;
        chk("full_pop_count", 64'(count), 64'd3);
        chk("full_pop_head", 64'(id_pc), 64'h604);
        step();
        chk("full_pop_next", 64'(id_pc), 64'h608);
        step();
        chk("full_pop_last", 64'(id_pc), 64'h60C);
        step();
        chk("full_pop_empty", 64'(id_valid), 64'd0);
        chk("full_pop_no610", 64'(id_pc), 64'd0);

        // Flush while full
        fill(32'h700, 4);
        chk("full3_ready", 64'(if_ready), 64'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_full_ready", 64'(if_ready), 64'd1);
        chk("flush_full_valid", 64'(id_valid), 64'd0);

        // Reset while full
        fill(32'h800, 4);
        chk("full4_count", 64'(count), 64'd4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_full_count", 64'(count), 64'd0);
        chk("rst_full_ready", 64'(if_ready), 64'd1);
        chk("rst_full_valid", 64'(id_valid), 64'd0);

`ifdef IFQ_BYPASS_EN
        // Same-cycle bypass on empty queue
        id_ready = 1'b1;
        if_valid = 1'b1;
        if_pc    = 32'h400;
        if_inst  = 32'h4000;
        #1;
        chk("byp_valid", 64'(id_valid), 64'd1);
        chk("byp_pc", 64'(id_pc), 64'h400);
        chk("byp_inst", 64'(id_inst), 64'h4000);
        step();
        if_valid = 1'b0;
        chk("byp_count", 64'(count), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
